// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: FSM states, funct3 size codes, error causes, request checks.
// Pure declarations and combinational helpers; no latency, no backpressure.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [1:0] lsu_err_cause_t;

    localparam lsu_err_cause_t ERR_MISALIGN = 2'b00;
    localparam lsu_err_cause_t ERR_ILLEGAL  = 2'b01;
    localparam lsu_err_cause_t ERR_TIMEOUT  = 2'b10;

    function automatic logic lsu_illegal(input logic ld, input logic st, input logic [2:0] f3);
        logic bad;
        if (ld && st) begin
            bad = 1'b1;
        end else if (ld) begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end else begin
            bad = (f3 >= 3'b011);
        end
        return bad;
    endfunction

    // Only meaningful once lsu_illegal() has passed; bits [1:0] then encode the size.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
               ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
// Purely combinational, zero latency; no handshake.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be_o   = 4'b1111;
        st_data_o = st_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_be_o   = 4'b0001 << addr_lo_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                st_be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_be_o   = 4'b1111;
                st_data_o = st_data_i;
            end
        endcase
    end

    always_comb begin
        ld_byte   = ld_word_i[{addr_lo_i, 3'b000} +: 8];
        ld_half   = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = ld_word_i;
        case (funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'b0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'b0, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one word-aligned req/gnt/rvalid bus access per load/store, with error reporting.
// Zero-wait latency: store done 2 cycles after accept, load 3, error 1; stalls EX until DONE.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t     state_q, state_d;
    logic           load_q, load_d;
    logic [2:0]     funct3_q, funct3_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    lsu_err_cause_t cause_q, cause_d;

    logic        ex_mem_op;
    logic        req_illegal;
    logic        req_misalign;
    logic        timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    assign ex_mem_op    = ex_load | ex_store;
    assign req_illegal  = lsu_illegal(ex_load, ex_store, ex_funct3);
    assign req_misalign = lsu_misaligned(ex_funct3, ex_addr[1:0]);
    assign timeout_hit  = (cnt_q == TO_LAST);

    lsu_lane_align u_lane_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .st_data_i (wdata_q),
        .ld_word_i (mem_rdata),
        .st_be_o   (st_be),
        .st_data_o (st_data),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ex_mem_op) begin
                    state_d = (req_illegal || req_misalign) ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = load_q ? WAIT : DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lsu_stall     = ex_mem_op && (state_q != DONE);
        lsu_done      = (state_q == DONE);
        lsu_rdata     = rdata_q;
        lsu_err       = err_q;
        lsu_err_cause = cause_q;
        mem_req       = (state_q == REQ);
        mem_we        = 1'b0;
        mem_addr      = 32'b0;
        mem_be        = 4'b0;
        mem_wdata     = 32'b0;
        if (state_q == REQ) begin
            mem_we    = !load_q;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_be    = load_q ? 4'b1111 : st_be;
            mem_wdata = load_q ? 32'b0 : st_data;
        end
    end

    // Result registers are only rewritten on the transition into DONE, so they hold in between.
    always_comb begin
        load_d   = load_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cause_d  = cause_q;
        case (state_q)
            IDLE: begin
                if (ex_mem_op) begin
                    load_d   = ex_load;
                    funct3_d = ex_funct3;
                    addr_d   = ex_addr;
                    wdata_d  = ex_wdata;
                    cnt_d    = 16'b0;
                    if (req_illegal) begin
                        rdata_d = 32'b0;
                        err_d   = 1'b1;
                        cause_d = ERR_ILLEGAL;
                    end else if (req_misalign) begin
                        rdata_d = 32'b0;
                        err_d   = 1'b1;
                        cause_d = ERR_MISALIGN;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    cnt_d = cnt_q + 16'd1;
                    if (!load_q) begin
                        rdata_d = 32'b0;
                        err_d   = 1'b0;
                        cause_d = ERR_MISALIGN;
                    end
                end else if (timeout_hit) begin
                    rdata_d = 32'b0;
                    err_d   = 1'b1;
                    cause_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = ld_data;
                    err_d   = 1'b0;
                    cause_d = ERR_MISALIGN;
                end else if (timeout_hit) begin
                    rdata_d = 32'b0;
                    err_d   = 1'b1;
                    cause_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q   <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            cnt_q    <= 16'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
            cause_q  <= 2'b0;
        end else begin
            load_q   <= load_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cause_q  <= cause_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane steering, extension, errors, wait states, timeout, reset.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [1:0]  lsu_err_cause;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_load       (ex_load),
        .ex_store      (ex_store),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .ex_wdata      (ex_wdata),
        .lsu_stall     (lsu_stall),
        .lsu_done      (lsu_done),
        .lsu_rdata     (lsu_rdata),
        .lsu_err       (lsu_err),
        .lsu_err_cause (lsu_err_cause),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait store: accept, REQ with gnt, DONE, back to IDLE.
    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd);
        ex_store = 1'b1; ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
        #1;
        chk({tag, ".stall_idle"}, 32'(lsu_stall), 32'd1);
        chk({tag, ".req_idle"}, 32'(mem_req), 32'd0);
        tick();
        chk({tag, ".req"}, 32'(mem_req), 32'd1);
        chk({tag, ".we"}, 32'(mem_we), 32'd1);
        chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({tag, ".be"}, 32'(mem_be), 32'(exp_be));
        chk({tag, ".wdata"}, mem_wdata, exp_wd);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        chk({tag, ".done"}, 32'(lsu_done), 32'd1);
        chk({tag, ".err"}, 32'(lsu_err), 32'd0);
        chk({tag, ".rdata"}, lsu_rdata, 32'd0);
        chk({tag, ".stall_done"}, 32'(lsu_stall), 32'd0);
        ex_store = 1'b0;
        tick();
        chk({tag, ".done_clr"}, 32'(lsu_done), 32'd0);
    endtask

    // Zero-wait load: gnt in first REQ cycle, rvalid in the following WAIT cycle.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input logic [31:0] exp_rd);
        ex_load = 1'b1; ex_funct3 = f3; ex_addr = addr;
        #1;
        chk({tag, ".stall_idle"}, 32'(lsu_stall), 32'd1);
        tick();
        chk({tag, ".req"}, 32'(mem_req), 32'd1);
        chk({tag, ".we"}, 32'(mem_we), 32'd0);
        chk({tag, ".be"}, 32'(mem_be), 32'hF);
        chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = word;
        #1;
        chk({tag, ".req_wait"}, 32'(mem_req), 32'd0);
        chk({tag, ".done_wait"}, 32'(lsu_done), 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk({tag, ".done"}, 32'(lsu_done), 32'd1);
        chk({tag, ".err"}, 32'(lsu_err), 32'd0);
        chk({tag, ".rdata"}, lsu_rdata, exp_rd);
        ex_load = 1'b0;
        tick();
        chk({tag, ".done_clr"}, 32'(lsu_done), 32'd0);
        chk({tag, ".rdata_hold"}, lsu_rdata, exp_rd);
    endtask

    // Rejected request: no bus activity, done on the next cycle with the error cause.
    task automatic run_err(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] exp_cause);
        ex_load = ld; ex_store = st; ex_funct3 = f3; ex_addr = addr; ex_wdata = 32'h5555_AAAA;
        #1;
        chk({tag, ".req_idle"}, 32'(mem_req), 32'd0);
        tick();
        chk({tag, ".req"}, 32'(mem_req), 32'd0);
        chk({tag, ".done"}, 32'(lsu_done), 32'd1);
        chk({tag, ".err"}, 32'(lsu_err), 32'd1);
        chk({tag, ".cause"}, 32'(lsu_err_cause), 32'(exp_cause));
        chk({tag, ".rdata"}, lsu_rdata, 32'd0);
        ex_load = 1'b0; ex_store = 1'b0;
        tick();
        chk({tag, ".done_clr"}, 32'(lsu_done), 32'd0);
        chk({tag, ".req_after"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.done", 32'(lsu_done), 32'd0);
        chk("rst.stall", 32'(lsu_stall), 32'd0);
        chk("rst.rdata", lsu_rdata, 32'd0);
        chk("rst.err", 32'(lsu_err), 32'd0);
        chk("rst.cause", 32'(lsu_err_cause), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        run_store("sb", 3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        run_store("sh", 3'b001, 32'h0000_1002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        run_store("sw", 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        run_load("lb",  3'b000, 32'h0000_2001, 32'h1234_80FF, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 32'h0000_2001, 32'h1234_80FF, 32'h0000_0080);
        run_load("lb3", 3'b000, 32'h0000_2003, 32'h7F00_0000, 32'h0000_007F);
        run_load("lh",  3'b001, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        run_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        run_load("lw",  3'b010, 32'h0000_2000, 32'h89AB_CDEF, 32'h89AB_CDEF);

        run_err("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_2002, 2'b00);
        run_err("lh_f011", 1'b1, 1'b0, 3'b011, 32'h0000_2000, 2'b01);
        run_err("sh_mis",  1'b0, 1'b1, 3'b001, 32'h0000_1001, 2'b00);
        run_err("s_f100",  1'b0, 1'b1, 3'b100, 32'h0000_1000, 2'b01);
        run_err("ld_st",   1'b1, 1'b1, 3'b010, 32'h0000_1000, 2'b01);

        // Grant withheld for 3 REQ cycles, rvalid 2 cycles after gnt.
        ex_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_3008;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("gw.req", 32'(mem_req), 32'd1);
            chk("gw.addr", mem_addr, 32'h0000_3008);
            chk("gw.stall", 32'(lsu_stall), 32'd1);
            tick();
        end
        chk("gw.req4", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("gw.wait_req", 32'(mem_req), 32'd0);
        chk("gw.wait_stall", 32'(lsu_stall), 32'd1);
        tick();
        chk("gw.wait2_done", 32'(lsu_done), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("gw.done", 32'(lsu_done), 32'd1);
        chk("gw.stall_done", 32'(lsu_stall), 32'd0);
        chk("gw.rdata", lsu_rdata, 32'h0BAD_F00D);
        ex_load = 1'b0;
        tick();

        // Timeout: grant never arrives, 8 REQ cycles then error.
        ex_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_4000;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to.req", 32'(mem_req), 32'd1);
            chk("to.done_early", 32'(lsu_done), 32'd0);
            tick();
        end
        chk("to.req_drop", 32'(mem_req), 32'd0);
        chk("to.done", 32'(lsu_done), 32'd1);
        chk("to.err", 32'(lsu_err), 32'd1);
        chk("to.cause", 32'(lsu_err_cause), 32'd2);
        chk("to.rdata", lsu_rdata, 32'd0);
        ex_load = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("stray.done", 32'(lsu_done), 32'd0);
        chk("stray.req", 32'(mem_req), 32'd0);
        chk("stray.rdata", lsu_rdata, 32'd0);
        chk("stray.cause", 32'(lsu_err_cause), 32'd2);

        // Reset while waiting for read data.
        ex_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_5004;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2;
        reset = 1'b1;
        ex_load = 1'b0;
        #1;
        chk("rw.req", 32'(mem_req), 32'd0);
        chk("rw.done", 32'(lsu_done), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        chk("rw.done2", 32'(lsu_done), 32'd0);
        chk("rw.rdata", lsu_rdata, 32'd0);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("rw.idle_done", 32'(lsu_done), 32'd0);
        chk("rw.idle_req", 32'(mem_req), 32'd0);
        run_load("lw_post", 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
